lc3_regfile_sb: RTL and testbench

Parametrised LC-3 general-purpose register file with two combinational read ports, one write port, write-through bypass and a per-register busy scoreboard for the pipelined datapath. Decode reserves the destination register and sees read-after-write hazards on the busy flags. Writeback clears the reservation. The block also owns the NZP condition code, which updates on every committed write. It replaces the single-cycle register file and is instantiated once in the datapath, between decode and writeback.

---
 rtl/lc3_pkg.sv | 14 +
 rtl/lc3_scoreboard.sv | 82 ++++++++
 rtl/lc3_regfile_sb.sv | 104 ++++++++++
 tb/tb_lc3_regfile_sb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: architectural widths, NZP encodings and register index type.
package lc3_pkg;

  localparam int LC3_DATA_W   = 16;
  localparam int LC3_NUM_REGS = 8;
  localparam int LC3_ADDR_W   = 3;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  typedef logic [LC3_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/lc3_scoreboard.sv
// Per-register busy scoreboard: reservation handshake, hazard flags for both read
// ports and a registered count of outstanding producers.
module lc3_scoreboard
  import lc3_pkg::*;
#(
  parameter int NUM_REGS = LC3_NUM_REGS,
  parameter int ADDR_W   = LC3_ADDR_W,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rsv_ok,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic [CNT_W-1:0]  pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [DEPTH-1:0]    busy_full;
  logic [CNT_W-1:0]    pending_reg;
  logic [CNT_W-1:0]    pending_next;
  logic                rsv_in_range;

  // Indices beyond NUM_REGS look permanently idle, so lookups never go out of bounds.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_full
      if (gi < NUM_REGS) begin : g_real
        assign busy_full[gi] = busy_reg[gi];
      end else begin : g_pad
        assign busy_full[gi] = 1'b0;
      end
    end
  endgenerate

  assign rsv_in_range = {1'b0, rsv_addr} < (ADDR_W+1)'(NUM_REGS);

  // A commit to the same register in this cycle frees it for the new producer.
  assign rsv_ok = rsv_en && rsv_in_range &&
                  (!busy_full[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

  assign rd_busy_a = busy_full[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
  assign rd_busy_b = busy_full[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));

  // Reservation takes priority over the clearing write: the new producer wins.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_next
      assign busy_next[gi] = (rsv_ok && (rsv_addr == ADDR_W'(gi))) ? 1'b1 :
                             (wr_en && (wr_addr == ADDR_W'(gi)))   ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_next = pending_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg    <= '0;
      pending_reg <= '0;
    end else begin
      busy_reg    <= busy_next;
      pending_reg <= pending_next;
    end
  end

  assign pending_cnt = pending_reg;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with write-through bypass, busy scoreboard and NZP condition code.
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter int DATA_W   = LC3_DATA_W,
  parameter int NUM_REGS = LC3_NUM_REGS,
  parameter int ADDR_W   = LC3_ADDR_W,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [2:0]        cc_nzp,
  output logic [CNT_W-1:0]  pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_full [DEPTH];
  logic              wr_in_range;
  logic              wr_commit;
  logic [2:0]        cc_reg;
  logic [2:0]        cc_next;

  assign wr_in_range = {1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS);
  assign wr_commit   = wr_en && wr_in_range;

  // One flop bank per architectural register; unused indices read as constant zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_regs
      if (gi < NUM_REGS) begin : g_real
        logic [DATA_W-1:0] data_reg;
        always_ff @(posedge clk) begin
          if (!rst) begin
            data_reg <= '0;
          end else if (wr_commit && (wr_addr == ADDR_W'(gi))) begin
            data_reg <= wr_data;
          end
        end
        assign regs_full[gi] = data_reg;
      end else begin : g_pad
        assign regs_full[gi] = '0;
      end
    end
  endgenerate

  assign rd_data_a = (wr_commit && (wr_addr == rd_addr_a)) ? wr_data : regs_full[rd_addr_a];
  assign rd_data_b = (wr_commit && (wr_addr == rd_addr_b)) ? wr_data : regs_full[rd_addr_b];

  always_comb begin
    cc_next = cc_reg;
    if (wr_commit) begin
      if (wr_data[DATA_W-1]) begin
        cc_next = CC_N;
      end else if (wr_data == '0) begin
        cc_next = CC_Z;
      end else begin
        cc_next = CC_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cc_reg <= CC_Z;
    end else begin
      cc_reg <= cc_next;
    end
  end

  assign cc_nzp = cc_reg;

  lc3_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rsv_ok      (rsv_ok),
    .rd_busy_a   (rd_busy_a),
    .rd_busy_b   (rd_busy_b),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Directed bench for lc3_regfile_sb: an 8-register build plus a 6-register build
// sharing the same stimulus for the out-of-range index cases.
module tb_lc3_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [15:0] wr_data;

  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b, rsv_ok;
  logic [2:0]  cc_nzp;
  logic [3:0]  pending_cnt;

  logic [15:0] s_rd_data_a, s_rd_data_b;
  logic        s_rd_busy_a, s_rd_busy_b, s_rsv_ok;
  logic [2:0]  s_cc_nzp;
  logic [3:0]  s_pending_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .cc_nzp(cc_nzp), .pending_cnt(pending_cnt)
  );

  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .CNT_W(4)) dut6 (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
    .rd_busy_a(s_rd_busy_a), .rd_busy_b(s_rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(s_rsv_ok),
    .cc_nzp(s_cc_nzp), .pending_cnt(s_pending_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    rsv_en = 1'b0; rsv_addr = 3'd0;

    // 1: reset beats a concurrent write
    step(); step();
    wr_en = 1'b0; #1;
    chk("rst_rd_a", rd_data_a, 16'h0);
    chk("rst_rd_b", rd_data_b, 16'h0);
    chk("rst_cc", cc_nzp, 3'b010);
    chk("rst_pend", pending_cnt, 4'd0);
    rst = 1'b1;

    // 2: bypass and NZP
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hFFFE; rd_addr_a = 3'd5; #1;
    chk("byp_rd_a", rd_data_a, 16'hFFFE);
    chk("byp_busy_a", rd_busy_a, 1'b0);
    step(); wr_en = 1'b0; #1;
    chk("r5_stored", rd_data_a, 16'hFFFE);
    chk("cc_neg", cc_nzp, 3'b100);
    wr_en = 1'b1; wr_data = 16'h0000;
    step(); wr_en = 1'b0; #1;
    chk("cc_zero", cc_nzp, 3'b010);
    chk("r5_zero", rd_data_a, 16'h0);

    // 3: reserve, deny, clear
    rsv_en = 1'b1; rsv_addr = 3'd2; #1;
    chk("rsv2_ok", rsv_ok, 1'b1);
    step(); rd_addr_a = 3'd2; #1;
    chk("r2_busy", rd_busy_a, 1'b1);
    chk("pend_1", pending_cnt, 4'd1);
    chk("rsv2_deny", rsv_ok, 1'b0);
    step();
    chk("pend_hold", pending_cnt, 4'd1);
    rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0007; #1;
    chk("r2_busy_resolved", rd_busy_a, 1'b0);
    chk("r2_byp", rd_data_a, 16'h0007);
    step(); wr_en = 1'b0; rd_addr_b = 3'd2; #1;
    chk("r2_idle", rd_busy_a, 1'b0);
    chk("pend_0", pending_cnt, 4'd0);
    chk("cc_pos", cc_nzp, 3'b001);
    chk("r2_rd_b", rd_data_b, 16'h0007);

    // 4: write and reserve the same busy register
    rsv_en = 1'b1; rsv_addr = 3'd4; step();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hABCD; #1;
    chk("r4_rsv_wr_ok", rsv_ok, 1'b1);
    step(); wr_en = 1'b0; rsv_en = 1'b0; rd_addr_a = 3'd4; #1;
    chk("r4_data", rd_data_a, 16'hABCD);
    chk("r4_busy", rd_busy_a, 1'b1);
    chk("r4_pend", pending_cnt, 4'd1);
    chk("r4_cc", cc_nzp, 3'b100);
    wr_en = 1'b1; wr_data = 16'h0001; step(); wr_en = 1'b0; #1;
    chk("r4_cleared", pending_cnt, 4'd0);

    // 5: several reservations, then reset drops them
    rsv_en = 1'b1;
    rsv_addr = 3'd1; step();
    rsv_addr = 3'd6; step();
    rsv_addr = 3'd7; step();
    rsv_en = 1'b0; rd_addr_a = 3'd6; rd_addr_b = 3'd1; #1;
    chk("pend_3", pending_cnt, 4'd3);
    chk("r6_busy", rd_busy_a, 1'b1);
    rsv_en = 1'b1; rsv_addr = 3'd6; #1;
    chk("r6_deny", rsv_ok, 1'b0);
    rst = 1'b0; step(); rst = 1'b1; rd_addr_a = 3'd4; #1;
    chk("pend_after_rst", pending_cnt, 4'd0);
    chk("r1_idle", rd_busy_b, 1'b0);
    chk("r4_reset", rd_data_a, 16'h0);
    chk("r6_retry_ok", rsv_ok, 1'b1);
    step(); rsv_en = 1'b0; #1;
    chk("pend_retry", pending_cnt, 4'd1);

    // 6: six-register build, out-of-range indices
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h8000; rd_addr_b = 3'd7; #1;
    chk("s_byp_oob", s_rd_data_b, 16'h0);
    step(); wr_en = 1'b0; rd_addr_a = 3'd6; #1;
    chk("s_cc_oob", s_cc_nzp, 3'b010);
    chk("s_rd6", s_rd_data_a, 16'h0);
    chk("s_busy6", s_rd_busy_a, 1'b0);
    chk("s_rd7", s_rd_data_b, 16'h0);
    rsv_en = 1'b1; rsv_addr = 3'd7; #1;
    chk("s_rsv7_deny", s_rsv_ok, 1'b0);
    step(); rsv_en = 1'b0; #1;
    chk("s_pend_oob", s_pending_cnt, 4'd0);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0001; rd_addr_a = 3'd5;
    step(); wr_en = 1'b0; #1;
    chk("s_cc_r5", s_cc_nzp, 3'b001);
    chk("s_rd5", s_rd_data_a, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
